// File: rtl/audio_input_mc.sv
// Multi-channel audio ADC front end: round-robin channel scan, unsigned-to-signed
// conversion, optional 2^AVG_LOG2 averaging, left-justified output samples.
module audio_input_mc #(
  parameter int BIT_DEPTH    = 12,
  parameter int TARGET_DEPTH = 16,
  parameter int NUM_CH       = 2,
  parameter int AVG_LOG2     = 2,
  parameter int SAMPLE_DIV   = 1000,
  parameter int CH_W         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_enable,
  output logic [CH_W-1:0]         o_adc_chsel,
  output logic                    o_adc_soc,
  input  logic                    i_adc_eoc,
  input  logic [BIT_DEPTH-1:0]    i_adc_data,
  output logic                    o_valid,
  output logic [CH_W-1:0]         o_channel,
  output logic [TARGET_DEPTH-1:0] o_sample,
  output logic                    o_overrun
);

  localparam int ACC_W = BIT_DEPTH + AVG_LOG2;
  localparam int RND_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam int CNT_W = $clog2(SAMPLE_DIV);
  localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(SAMPLE_DIV - 1);
  localparam logic [CH_W-1:0]      CH_LAST  = CH_W'(NUM_CH - 1);
  localparam logic [RND_W-1:0]     RND_LAST = RND_W'((1 << AVG_LOG2) - 1);
  localparam logic [BIT_DEPTH-1:0] MSB_MASK = BIT_DEPTH'(1'b1) << (BIT_DEPTH - 1);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_START   = 3'd1,
    ST_CONVERT = 3'd2,
    ST_ACCUM   = 3'd3,
    ST_OUTPUT  = 3'd4
  } state_e;

  state_e                      state_q, state_d;
  logic [CNT_W-1:0]            cnt_q, cnt_d;
  logic                        tick_s;
  logic [CH_W-1:0]             ch_q, ch_d;
  logic [RND_W-1:0]            round_q, round_d;
  logic signed [BIT_DEPTH-1:0] samp_q, samp_d;
  logic signed [ACC_W-1:0]     acc_q [NUM_CH];
  logic signed [ACC_W-1:0]     acc_d [NUM_CH];
  logic signed [ACC_W-1:0]     acc_sum [NUM_CH];
  logic                        soc_q, soc_d;
  logic [CH_W-1:0]             chsel_q, chsel_d;
  logic                        valid_q, valid_d;
  logic [CH_W-1:0]             chan_q, chan_d;
  logic [TARGET_DEPTH-1:0]     sample_q, sample_d;
  logic                        ovr_q, ovr_d;

  // Dropping the low AVG_LOG2 bits of the accumulator is the floor division by 2^AVG_LOG2.
  function automatic logic [TARGET_DEPTH-1:0] fmt_sample(input logic signed [ACC_W-1:0] a);
    logic [TARGET_DEPTH-1:0] w;
    w = TARGET_DEPTH'(a[ACC_W-1:AVG_LOG2]);
    return w << (TARGET_DEPTH - BIT_DEPTH);
  endfunction

  assign tick_s = i_enable && (cnt_q == CNT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= {CNT_W{1'b0}};
      ch_q     <= {CH_W{1'b0}};
      round_q  <= {RND_W{1'b0}};
      samp_q   <= {BIT_DEPTH{1'b0}};
      soc_q    <= 1'b0;
      chsel_q  <= {CH_W{1'b0}};
      valid_q  <= 1'b0;
      chan_q   <= {CH_W{1'b0}};
      sample_q <= {TARGET_DEPTH{1'b0}};
      ovr_q    <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) acc_q[i] <= {ACC_W{1'b0}};
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ch_q     <= ch_d;
      round_q  <= round_d;
      samp_q   <= samp_d;
      soc_q    <= soc_d;
      chsel_q  <= chsel_d;
      valid_q  <= valid_d;
      chan_q   <= chan_d;
      sample_q <= sample_d;
      ovr_q    <= ovr_d;
      for (int i = 0; i < NUM_CH; i++) acc_q[i] <= acc_d[i];
    end
  end

  always_comb begin
    state_d = state_q;
    if (!i_enable) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:    if (tick_s) state_d = ST_START; else state_d = ST_IDLE;
        ST_START:   state_d = ST_CONVERT;
        ST_CONVERT: if (i_adc_eoc) state_d = ST_ACCUM; else state_d = ST_CONVERT;
        ST_ACCUM: begin
          if (ch_q != CH_LAST)         state_d = ST_START;
          else if (round_q == RND_LAST) state_d = ST_OUTPUT;
          else                          state_d = ST_IDLE;
        end
        ST_OUTPUT:  if (ch_q == CH_LAST) state_d = ST_IDLE; else state_d = ST_OUTPUT;
        default:    state_d = ST_IDLE;
      endcase
    end
  end

  // ch_q doubles as the emission index k while in OUTPUT.
  always_comb begin
    cnt_d    = cnt_q;
    ch_d     = ch_q;
    round_d  = round_q;
    samp_d   = samp_q;
    ovr_d    = ovr_q;
    soc_d    = 1'b0;
    chsel_d  = chsel_q;
    valid_d  = 1'b0;
    chan_d   = chan_q;
    sample_d = sample_q;
    for (int i = 0; i < NUM_CH; i++) acc_sum[i] = acc_q[i];

    if (!i_enable) begin
      cnt_d   = {CNT_W{1'b0}};
      ch_d    = {CH_W{1'b0}};
      round_d = {RND_W{1'b0}};
      ovr_d   = 1'b0;
      for (int i = 0; i < NUM_CH; i++) acc_sum[i] = {ACC_W{1'b0}};
    end else begin
      if (tick_s) cnt_d = {CNT_W{1'b0}}; else cnt_d = cnt_q + CNT_W'(1'b1);
      if (tick_s && (state_q != ST_IDLE)) ovr_d = 1'b1; else ovr_d = ovr_q;
      case (state_q)
        ST_IDLE: if (tick_s) ch_d = {CH_W{1'b0}}; else ch_d = ch_q;
        ST_CONVERT: begin
          if (i_adc_eoc) samp_d = $signed(i_adc_data ^ MSB_MASK); else samp_d = samp_q;
        end
        ST_ACCUM: begin
          acc_sum[ch_q] = acc_q[ch_q] + ACC_W'(samp_q);
          if (ch_q != CH_LAST) begin
            ch_d = ch_q + CH_W'(1'b1);
          end else begin
            ch_d = {CH_W{1'b0}};
            if (round_q == RND_LAST) round_d = {RND_W{1'b0}};
            else                     round_d = round_q + RND_W'(1'b1);
          end
        end
        ST_OUTPUT: if (ch_q != CH_LAST) ch_d = ch_q + CH_W'(1'b1); else ch_d = {CH_W{1'b0}};
        default: ch_d = ch_q;
      endcase
    end

    for (int i = 0; i < NUM_CH; i++) acc_d[i] = acc_sum[i];

    if (state_d == ST_START) begin
      soc_d   = 1'b1;
      chsel_d = ch_d;
    end else begin
      soc_d   = 1'b0;
      chsel_d = chsel_q;
    end

    // Outputs are registered one cycle ahead of the OUTPUT state they belong to.
    if (state_d == ST_OUTPUT) begin
      valid_d      = 1'b1;
      chan_d       = ch_d;
      sample_d     = fmt_sample(acc_sum[ch_d]);
      acc_d[ch_d]  = {ACC_W{1'b0}};
    end else begin
      valid_d  = 1'b0;
      chan_d   = chan_q;
      sample_d = sample_q;
    end
  end

  assign o_adc_soc   = soc_q;
  assign o_adc_chsel = chsel_q;
  assign o_valid     = valid_q;
  assign o_channel   = chan_q;
  assign o_sample    = sample_q;
  assign o_overrun   = ovr_q;

endmodule
